// File: rtl/uart_rx_frame_ctrl.sv
// Receive frame controller: assembles LSB-first bits into bytes and queues them in a FWFT FIFO.
// Optional error counters are enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_frame_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          bit_ready,
    input  logic                          rx_bit,
    input  logic                          done,
    input  logic                          framing_err,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]          frame_err_cnt,
    output logic [CNT_WIDTH-1:0]          overrun_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        WAIT_STOP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [7:0]         shift_data_reg;
    logic [3:0]         bit_cnt_reg;

    logic [7:0]         mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               frame_err_reg;
    logic               overrun_reg;

    logic               stop_seen;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               frame_err_ev;
    logic               overrun_ev;

    // A stop strobe only counts while enabled; an en-low cycle aborts the frame outright.
    assign stop_seen    = (state_reg == WAIT_STOP) && en && done;
    assign push         = stop_seen && !framing_err;
    assign frame_err_ev = stop_seen && framing_err;
    assign full         = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop          = (count_reg != '0) && data_ready;
    assign wr_en        = push && (!full || pop);
    assign overrun_ev   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            shift_data_reg <= 8'h00;
            bit_cnt_reg    <= 4'd0;
        end else if (!en) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bit_ready) begin
                        shift_data_reg <= {rx_bit, 7'b0};
                        bit_cnt_reg    <= 4'd1;
                        state_reg      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (done) begin
                        // Stop strobe before eight bits: silently drop the partial byte.
                        state_reg   <= IDLE;
                        bit_cnt_reg <= 4'd0;
                    end else if (bit_ready) begin
                        shift_data_reg <= {rx_bit, shift_data_reg[7:1]};
                        bit_cnt_reg    <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            state_reg <= WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    if (done) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= 4'd0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= 4'd0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_reg[gi] <= 8'h00;
                end else if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= shift_data_reg;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // A new error in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_err_ev) begin
                frame_err_reg <= 1'b1;
            end else if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
            if (overrun_ev) begin
                overrun_reg <= 1'b1;
            end else if (clr_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] frame_err_cnt_reg;
    logic [CNT_WIDTH-1:0] overrun_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_cnt_reg <= '0;
            overrun_cnt_reg   <= '0;
        end else begin
            if (frame_err_ev) begin
                if (clr_err) begin
                    frame_err_cnt_reg <= CNT_WIDTH'(1);
                end else if (frame_err_cnt_reg != '1) begin
                    frame_err_cnt_reg <= frame_err_cnt_reg + CNT_WIDTH'(1);
                end
            end else if (clr_err) begin
                frame_err_cnt_reg <= '0;
            end
            if (overrun_ev) begin
                if (clr_err) begin
                    overrun_cnt_reg <= CNT_WIDTH'(1);
                end else if (overrun_cnt_reg != '1) begin
                    overrun_cnt_reg <= overrun_cnt_reg + CNT_WIDTH'(1);
                end
            end else if (clr_err) begin
                overrun_cnt_reg <= '0;
            end
        end
    end

    assign frame_err_cnt = frame_err_cnt_reg;
    assign overrun_cnt   = overrun_cnt_reg;
`endif

    assign data_out   = mem_reg[rd_ptr_reg];
    assign data_valid = (count_reg != '0);
    assign fifo_count = count_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frames, FIFO full/overrun, aborts and sticky flags.
// Counter checks run only when UART_RX_ERR_CNT_EN is defined.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, bit_ready, rx_bit, done, framing_err;
    logic [7:0] data_out;
    logic       data_valid, data_ready;
    logic [2:0] fifo_count;
    logic       frame_err, overrun, clr_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] frame_err_cnt, overrun_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    uart_rx_frame_ctrl #(.FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bit_ready(bit_ready), .rx_bit(rx_bit),
        .done(done), .framing_err(framing_err), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .fifo_count(fifo_count),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
`ifdef UART_RX_ERR_CNT_EN
        , .frame_err_cnt(frame_err_cnt), .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bit_ready = 1'b1;
            rx_bit    = b[i];
            tick();
        end
        bit_ready = 1'b0;
        rx_bit    = 1'b0;
    endtask

    task automatic send_done(input logic fe, input logic rdy, input logic clr);
        done        = 1'b1;
        framing_err = fe;
        data_ready  = rdy;
        clr_err     = clr;
        tick();
        done        = 1'b0;
        framing_err = 1'b0;
        data_ready  = 1'b0;
        clr_err     = 1'b0;
    endtask

    task automatic pop_one();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; bit_ready = 1'b0; rx_bit = 1'b0; done = 1'b0;
        framing_err = 1'b0; data_ready = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        chk("reset_valid", data_valid, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_data", data_out, 8'h00);
        chk("reset_ferr", frame_err, 0);
        chk("reset_ovr", overrun, 0);

        // Bits 1,0,1,0,0,1,0,1 LSB-first form 8'hA5.
        send_bits(8'hA5, 8);
        send_done(1'b0, 1'b0, 1'b0);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_valid", data_valid, 1);
        chk("a5_count", fifo_count, 1);
        pop_one();
        chk("a5_popped", data_valid, 0);

        for (int i = 1; i <= 5; i++) begin
            send_bits(8'(i), 8);
            send_done(1'b0, 1'b0, 1'b0);
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_ovr", overrun, 1);
        chk("fill_ferr", frame_err, 0);
`ifdef UART_RX_ERR_CNT_EN
        chk("fill_ovr_cnt", overrun_cnt, 1);
`endif
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("pop_%0d", i), data_out, i);
            pop_one();
        end
        chk("drain_valid", data_valid, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovr_clear", overrun, 0);

        send_bits(8'h3C, 8);
        send_done(1'b1, 1'b0, 1'b0);
        chk("fe_count", fifo_count, 0);
        chk("fe_flag", frame_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("fe_clear", frame_err, 0);

        // Abort after 4 bits; the bit_ready coincident with en falling must be ignored.
        send_bits(8'h00, 4);
        en = 1'b0; bit_ready = 1'b1; rx_bit = 1'b0;
        tick();
        bit_ready = 1'b0; en = 1'b1;
        send_bits(8'hFF, 8);
        send_done(1'b0, 1'b0, 1'b0);
        chk("abort_count", fifo_count, 1);
        chk("abort_data", data_out, 8'hFF);
        pop_one();

        for (int i = 0; i < 4; i++) begin
            send_bits(8'h10 + 8'(i), 8);
            send_done(1'b0, 1'b0, 1'b0);
        end
        chk("full_count", fifo_count, 4);
        send_bits(8'h77, 8);
        send_done(1'b0, 1'b1, 1'b0);
        chk("fullpp_count", fifo_count, 4);
        chk("fullpp_ovr", overrun, 0);
        chk("fullpp_head", data_out, 8'h11);
        pop_one();
        chk("fullpp_12", data_out, 8'h12);
        pop_one();
        chk("fullpp_13", data_out, 8'h13);
        pop_one();
        chk("fullpp_tail", data_out, 8'h77);
        pop_one();
        chk("fullpp_empty", data_valid, 0);

        // done in COLLECT drops the partial byte without flags.
        send_bits(8'h07, 3);
        send_done(1'b0, 1'b0, 1'b0);
        chk("proto_count", fifo_count, 0);
        chk("proto_ferr", frame_err, 0);
        send_bits(8'h5A, 8);
        send_done(1'b0, 1'b0, 1'b0);
        chk("proto_next", data_out, 8'h5A);
        pop_one();

        // Extra bit_ready in WAIT_STOP is ignored.
        send_bits(8'hC3, 8);
        send_bits(8'h01, 1);
        send_done(1'b0, 1'b0, 1'b0);
        chk("waitstop_data", data_out, 8'hC3);
        chk("waitstop_count", fifo_count, 1);
        pop_one();

        send_bits(8'h99, 8);
        send_done(1'b1, 1'b0, 1'b1);
        chk("clr_vs_err", frame_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_after", frame_err, 0);

`ifdef UART_RX_ERR_CNT_EN
        chk("cnt_clr_fe", frame_err_cnt, 0);
        chk("cnt_clr_ovr", overrun_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            send_bits(8'h3C, 8);
            send_done(1'b1, 1'b0, 1'b0);
        end
        chk("cnt_sat", frame_err_cnt, 8'hFF);
        send_bits(8'h3C, 8);
        send_done(1'b1, 1'b0, 1'b1);
        chk("cnt_clr_ev", frame_err_cnt, 1);
        chk("cnt_clr_flag", frame_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller for the flex-uart receiver. It consumes the per-bit strobes produced by the oversampling bit detector and assembles them LSB-first into bytes. Valid bytes are queued in a small first-word-fall-through FIFO that feeds the host through a valid/ready handshake. The block also tracks framing and overrun errors for the host and discards corrupted or aborted frames.

## Interface
Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- CNT_WIDTH, 8: width of error counters (only with UART_RX_ERR_CNT_EN).

Ports:
- clk  input  1  peripheral clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  receive enable; low aborts any frame in progress.
- bit_ready  input  1  one-cycle strobe: rx_bit holds a new data bit.
- rx_bit  input  1  sampled data bit, valid when bit_ready or done is high.
- done  input  1  one-cycle strobe at the end of the stop bit.
- framing_err  input  1  qualified by done; stop bit sampled low.
- data_out  output  8  FIFO head byte.
- data_valid  output  1  FIFO non-empty.
- data_ready  input  1  host accepts data_out when data_valid && data_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.
- frame_err  output  1  sticky framing-error flag.
- overrun  output  1  sticky overrun flag.
- clr_err  input  1  clears frame_err, overrun, and counters.
- frame_err_cnt  output  CNT_WIDTH  framing errors seen (macro only).
- overrun_cnt  output  CNT_WIDTH  bytes dropped on full FIFO (macro only).

## Operation
- FSM states: IDLE, COLLECT, WAIT_STOP.
- IDLE: bit_ready && en loads rx_bit, sets bit count to 1, and moves to COLLECT. done is ignored.
- COLLECT: each bit_ready shifts right with rx_bit entering bit 7 (LSB-first) and increments the bit count. The 8th bit moves to WAIT_STOP. A done here is a protocol error: drop the partial byte, return to IDLE, no flags.
- WAIT_STOP: further bit_ready strobes are ignored. On done:
  - framing_err=1: drop the byte, set frame_err, go to IDLE.
  - framing_err=0: push the byte, go to IDLE.
- en low in COLLECT/WAIT_STOP: return to IDLE next cycle and discard the partial byte. FIFO contents are kept; pops still work.
- FIFO: registered storage, wrapping read/write pointers.
  - data_out = mem[rd_ptr]; data_valid = (fifo_count != 0).
  - Pop on data_valid && data_ready. A pop when empty is ignored.
  - Push while full with a simultaneous pop: both happen; count unchanged; no overrun.
  - Push while full without a pop: byte dropped, set overrun; FIFO unchanged.
  - Simultaneous push and pop when not full: count unchanged.
- Sticky flags: clr_err clears them. If clr_err and a new error occur in the same cycle, the error wins (flag reads 1).
- Reset values: state IDLE; shift register 0; pointers 0; data_out 0 (memory reset to 0); data_valid 0; fifo_count 0; frame_err 0; overrun 0; counters 0.

## Timing
- done (good frame) → byte at data_out with data_valid=1 on the next cycle when the FIFO was empty.
- Pop takes effect at the clock edge. The next entry, if any, is presented the following cycle with no bubble.
- Flags and counters update one cycle after the causing done strobe.
- clr_err takes effect one cycle later.
- The en-low abort takes one cycle. A bit_ready in the same cycle as en falling is ignored.
- No combinational path from data_ready to data_valid or data_out.

## Configuration
- UART_RX_ERR_CNT_EN defined: frame_err_cnt and overrun_cnt ports exist.
  - Each increments by 1 per event, alongside the sticky flag.
  - Each saturates at all-ones.
  - Both clear on clr_err; an event in the same cycle as clr_err leaves the count at 1.
- Not defined: counter ports and logic are absent. Sticky flags behave identically.

## Test plan
- Reset, then bits 1,0,1,0,0,1,0,1 via bit_ready, then done with framing_err=0 → data_out=8'hA5, data_valid=1 the cycle after done, fifo_count=1.
- Hold data_ready=0 and send 5 good frames, 8'h01..8'h05, with FIFO_DEPTH=4 → FIFO holds 01..04 and overrun=1 (overrun_cnt=1). Pop 4 → 01,02,03,04 in order, then data_valid=0.
- Byte 8'h3C completed with done and framing_err=1 → no push, frame_err=1, fifo_count unchanged. Then clr_err=1 → frame_err=0 the next cycle.
- Drop en after 4 bits, raise en, send a full 8'hFF frame → only 8'hFF is queued; the partial byte never appears.
- FIFO full with data_ready=1 and done for 8'h77 in the same cycle → head popped, 8'h77 written at the tail, fifo_count stays 4, overrun=0.
- With the macro defined, 300 framing errors at CNT_WIDTH=8 → frame_err_cnt=8'hFF. Then clr_err coincident with a framing error → frame_err_cnt=1, frame_err=1.
